dual_addressable_latch: RTL and testbench
=========================================

# dual_addressable_latch

Dual 1-of-4 addressable latch: the write-side counterpart of the team's dual 4:1 data selector. A shared 2-bit address steers each channel's single data bit into one of four registered outputs. The block replaces a 74x259-style part in the TTL CPU model, where it fans a serial control line out into latched enables. An optional internal scan counter walks the address 0→3 so a selector on the far end can be mirrored slot by slot.

## Interface
Parameters:
- RESET_VALUE, 4'b0000, value loaded into q1 and q2 on reset.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  synchronous reset, active low
- a  input  1  address bit 0 (external)
- b  input  1  address bit 1 (external)
- scan  input  1  1 = address from internal counter, 0 = address is {b,a}
- enable1  input  1  channel 1 enable, active low
- enable2  input  1  channel 2 enable, active low
- clear1  input  1  channel 1 clear, active low, synchronous
- clear2  input  1  channel 2 clear, active low, synchronous
- d1  input  1  channel 1 data bit
- d2  input  1  channel 2 data bit
- q1  output  4  channel 1 latched outputs, index = address
- q2  output  4  channel 2 latched outputs
- addr  output  2  effective address used this cycle
- wrap  output  1  registered pulse, high one cycle after counter goes 3→0

## Operation
- Effective address sel = scan ? cnt : {b,a}; addr = sel (combinational).
- Each channel n runs independently on its own enable/clear, with shared sel. At each rising edge:
  - enable=0, clear=1 (latch): qn[sel] <= dn; other bits hold.
  - enable=1, clear=1 (hold): qn unchanged.
  - enable=0, clear=0 (demux): qn <= 0, except qn[sel] <= dn.
  - enable=1, clear=0 (clear): qn <= 4'b0000.
- Scan counter cnt (2 bits):
  - Increments by 1 mod 4 on each edge with scan=1; holds when scan=0.
  - Counts regardless of enables.
- wrap <= (scan && cnt==3) at each edge, else 0.
- Reset (rst_n=0 at edge): q1=q2=RESET_VALUE, cnt=0, wrap=0. Reset overrides every other input.

## Timing
- Write latency 1 cycle: d sampled at edge k appears on q at edge k (visible in cycle k+1).
- Scan mode uses the pre-increment cnt as the write address. Slot 0 is written on the first scan edge after reset, slots 1, 2, 3 on the following edges, then 0 again.
- wrap is high in the cycle after the slot-3 write, coincident with addr=0.
- Toggling scan mid-sequence freezes cnt at its current value. Re-asserting scan resumes from that value; there is no reset to 0.
- Switching scan 1→0 takes effect combinationally: that same edge uses {b,a}.
- Asynchronous changes of a/b/d between edges have no effect; only edge-sampled values matter.
- No combinational path from d to q. addr is combinational from a, b, scan and cnt.

## Test plan
- Reset: with RESET_VALUE=4'b1010, hold rst_n=0 for 2 edges with all other inputs random → q1=q2=4'b1010, addr=0 when scan=1, wrap=0.
- Latch mode: after reset to 0, channel 1 writes d1=1 at {b,a}=2, then d1=1 at 0 → q1=0100 then 0101. q2 holds with enable2=1.
- Demux and clear modes: q1=1111. Set clear1=0, enable1=0, sel=3, d1=1 → q1=1000. Next edge enable1=1 → q1=0000. Channel 2 is unaffected throughout.
- Scan sweep: scan=1, enable1=0, d1 driven 1,0,1,1 on four edges → q1=1101. wrap is high exactly in the 5th cycle and otherwise 0 over 8 edges.
- Scan pause: scan=1 for 2 edges (cnt=2), scan=0 for 3 edges using {b,a}=0, scan=1 again → next scan write lands at index 2, and wrap fires after index 3.
- Reset mid-scan: cnt=3 with scan=1, assert rst_n=0 for one edge → cnt=0, wrap stays 0, q=RESET_VALUE, and the next scan write targets index 0.

Source files
------------

// File: rtl/dual_addressable_latch.sv
// Dual 1-of-4 addressable latch with shared address and optional internal scan counter.
// Each channel writes its data bit into one of four registered outputs selected by addr.
module dual_addressable_latch #(
  parameter logic [3:0] RESET_VALUE = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       scan,
  input  logic       enable1,
  input  logic       enable2,
  input  logic       clear1,
  input  logic       clear2,
  input  logic       d1,
  input  logic       d2,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [1:0] addr,
  output logic       wrap
);

  logic [1:0] cnt_q, cnt_d;
  logic       wrap_q, wrap_d;
  logic [3:0] q1_q, q1_d;
  logic [3:0] q2_q, q2_d;
  logic [1:0] sel;

  // Clear (active low) zeroes the channel first; enable (active low) then writes d at sel.
  function automatic logic [3:0] chan_next(input logic [3:0] q, input logic [1:0] s,
                                           input logic en_n, input logic clr_n,
                                           input logic d);
    logic [3:0] nxt;
    nxt = clr_n ? q : 4'b0000;
    if (!en_n) begin
      nxt[s] = d;
    end
    return nxt;
  endfunction

  always_comb begin
    sel = scan ? cnt_q : {b, a};
  end

  always_comb begin
    q1_d   = chan_next(q1_q, sel, enable1, clear1, d1);
    q2_d   = chan_next(q2_q, sel, enable2, clear2, d2);
    cnt_d  = scan ? cnt_q + 2'd1 : cnt_q;
    wrap_d = scan && (cnt_q == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1_q   <= RESET_VALUE;
      q2_q   <= RESET_VALUE;
      cnt_q  <= 2'd0;
      wrap_q <= 1'b0;
    end else begin
      q1_q   <= q1_d;
      q2_q   <= q2_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign q1   = q1_q;
  assign q2   = q2_q;
  assign addr = sel;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dual_addressable_latch.sv
// Scoreboard bench: stimulus pushes expectations from an array-based model, a monitor compares.
module tb_dual_addressable_latch;

  localparam logic [3:0] RV = 4'b1010;

  logic       clk = 1'b0;
  logic       rst_n, a, b, scan, enable1, enable2, clear1, clear2, d1, d2;
  logic [3:0] q1, q2;
  logic [1:0] addr;
  logic       wrap;

  always #5 clk = ~clk;

  dual_addressable_latch #(.RESET_VALUE(RV)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .scan(scan),
    .enable1(enable1), .enable2(enable2), .clear1(clear1), .clear2(clear2),
    .d1(d1), .d2(d2), .q1(q1), .q2(q2), .addr(addr), .wrap(wrap)
  );

  typedef struct {
    logic [3:0] q1;
    logic [3:0] q2;
    logic       wrap;
  } exp_t;

  exp_t       state_q[$];
  logic [1:0] addr_q[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model: plain arrays of bits and an integer slot counter.
  int m_q1[4];
  int m_q2[4];
  int m_cnt;
  int m_wrap;

  function automatic logic [3:0] pack(input int v[4]);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (v[i] != 0);
    return r;
  endfunction

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit aa, input bit bb,
                      input bit e1, input bit e2, input bit c1, input bit c2,
                      input bit x1, input bit x2);
    int   sel;
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = r; scan = s; a = aa; b = bb; enable1 = e1; enable2 = e2;
    clear1 = c1; clear2 = c2; d1 = x1; d2 = x2;
    sel = s ? m_cnt : (bb ? 2 : 0) + (aa ? 1 : 0);
    addr_q.push_back(2'(sel));
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        m_q1[i] = RV[i];
        m_q2[i] = RV[i];
      end
      m_cnt  = 0;
      m_wrap = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!c1) m_q1[i] = 0;
        if (!c2) m_q2[i] = 0;
      end
      if (!e1) m_q1[sel] = x1;
      if (!e2) m_q2[sel] = x2;
      m_wrap = (s && m_cnt == 3) ? 1 : 0;
      if (s) m_cnt = (m_cnt + 1) % 4;
    end
    e.q1   = pack(m_q1);
    e.q2   = pack(m_q2);
    e.wrap = (m_wrap != 0);
    state_q.push_back(e);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Monitor: post-edge state at negedge, combinational addr just after inputs settle.
  initial begin
    exp_t e;
    logic [1:0] ea;
    forever begin
      @(negedge clk);
      if (state_q.size() > 0) begin
        e = state_q.pop_front();
        check4("q1", q1, e.q1);
        check4("q2", q2, e.q2);
        check4("wrap", {3'b0, wrap}, {3'b0, e.wrap});
      end
      #2;
      if (addr_q.size() > 0) begin
        ea = addr_q.pop_front();
        check4("addr", {2'b0, addr}, {2'b0, ea});
      end
    end
  end

  initial begin
    rst_n = 1'b0; scan = 1'b0; a = 1'b0; b = 1'b0; enable1 = 1'b1; enable2 = 1'b1;
    clear1 = 1'b1; clear2 = 1'b1; d1 = 1'b0; d2 = 1'b0;
    m_cnt = 0; m_wrap = 0;
    for (int i = 0; i < 4; i++) begin
      m_q1[i] = 0;
      m_q2[i] = 0;
    end

    // Reset with random side inputs, scan=1 so addr must read 0.
    repeat (2) step(0, 1, rb(), rb(), rb(), rb(), rb(), rb(), rb(), rb());

    // Latch mode: zero channel 1, then write slot 2 and slot 0; channel 2 holds.
    step(1, 0, rb(), rb(), 1, 1, 0, 1, rb(), rb());
    step(1, 0, 0, 1, 0, 1, 1, 1, 1, rb());
    step(1, 0, 0, 0, 0, 1, 1, 1, 1, rb());

    // Demux then clear on channel 1 from 1111.
    for (int i = 0; i < 4; i++) step(1, 0, i[0], i[1], 0, 1, 1, 1, 1, rb());
    step(1, 0, 1, 1, 0, 1, 0, 1, 1, rb());
    step(1, 0, rb(), rb(), 1, 1, 0, 1, rb(), rb());

    // Scan sweep from a fresh counter: d1 = 1,0,1,1 then four idle scan edges.
    step(0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    step(1, 1, rb(), rb(), 0, 1, 1, 1, 1, rb());
    step(1, 1, rb(), rb(), 0, 1, 1, 1, 0, rb());
    step(1, 1, rb(), rb(), 0, 1, 1, 1, 1, rb());
    step(1, 1, rb(), rb(), 0, 1, 1, 1, 1, rb());
    repeat (4) step(1, 1, rb(), rb(), 1, 1, 1, 1, rb(), rb());

    // Scan pause: two scan edges, three external writes at slot 0, then resume.
    step(0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    repeat (2) step(1, 1, rb(), rb(), 0, 0, 1, 1, rb(), rb());
    repeat (3) step(1, 0, 0, 0, 0, 0, 1, 1, rb(), rb());
    repeat (4) step(1, 1, rb(), rb(), 0, 0, 1, 1, rb(), rb());

    // Reset mid-scan at cnt=3, then continue scanning.
    step(0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    repeat (3) step(1, 1, rb(), rb(), 1, 1, 1, 1, rb(), rb());
    step(0, 1, rb(), rb(), rb(), rb(), rb(), rb(), rb(), rb());
    repeat (5) step(1, 1, rb(), rb(), 0, 0, 1, 1, rb(), rb());

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 15) != 0), rb(), rb(), rb(), rb(), rb(),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), rb(), rb());
    end

    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (state_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0", state_q.size(), addr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
